rx_timer_ctrl: RTL and testbench

RX_TIMER_CTRL -- requirements
Module: rx_timer_ctrl

---
 rtl/rx_timer_ctrl.sv | 157 +++++++++++++++
 tb/tb_rx_timer_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_timer_ctrl.sv
// ============================================================================
// rx_timer_ctrl
// ----------------------------------------------------------------------------
// Bit timer for a serial receiver. When the receiver control unit raises
// enable_timer, the block latches the bit period and the packet length. It
// then issues one shift_strobe per bit: N data bits plus the stop bit. One
// packet_done pulse follows the stop-bit strobe. The block then holds until
// enable_timer is released. All outputs are registered.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   enable_timer in   1   high while packet reception is in progress
//   bit_period   in  14   clock cycles per bit, sampled at packet start
//   data_bits    in   4   data bits per packet (no stop bit), sampled at start
//   shift_strobe out  1   one-cycle pulse: shift register samples serial_in
//   packet_done  out  1   one-cycle pulse after the stop bit was sampled
//   bit_index    out  4   strobes issued in the current packet
//   busy         out  1   high whenever the FSM is not IDLE
//
// Build option
//   RX_TIMER_MIDSAMPLE_EN  when defined, the first strobe comes 1.5 bit
//                          periods after packet start, so every data bit is
//                          sampled mid-bit. Later strobes stay one period apart.
// ============================================================================
module rx_timer_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_timer,
    input  logic [13:0] bit_period,
    input  logic [3:0]  data_bits,
    output logic        shift_strobe,
    output logic        packet_done,
    output logic [3:0]  bit_index,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [14:0] cnt, cnt_nxt;
    logic [13:0] p_lat, p_nxt;
    logic [3:0]  n_lat, n_nxt;
    logic [3:0]  idx_nxt;
    logic        strobe_nxt;
    logic        done_nxt;
    logic        busy_nxt;

    // Periods below 2 cannot produce distinct strobes; treat them as 2.
    function automatic logic [13:0] clamp_period(input logic [13:0] p);
        return (p < 14'd2) ? 14'd2 : p;
    endfunction

    // Only 5..8 data bits are meaningful; anything else means 8.
    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        return ((n < 4'd5) || (n > 4'd8)) ? 4'd8 : n;
    endfunction

    // The counter expires when it reaches zero, so load (delay - 1).
    // The 15-bit width holds 1.5 * 16383 without overflow.
    function automatic logic [14:0] first_load(input logic [13:0] p);
`ifdef RX_TIMER_MIDSAMPLE_EN
        return {1'b0, p} + {2'b00, p[13:1]} - 15'd1;
`else
        return {1'b0, p} - 15'd1;
`endif
    endfunction

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        p_nxt      = p_lat;
        n_nxt      = n_lat;
        idx_nxt    = bit_index;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable_timer) begin
                    state_nxt = COUNT;
                    p_nxt     = clamp_period(bit_period);
                    n_nxt     = clamp_bits(data_bits);
                    idx_nxt   = 4'd0;
                    cnt_nxt   = first_load(clamp_period(bit_period));
                end
            end
            COUNT: begin
                if (!enable_timer) begin
                    // Abort: drop the packet without issuing anything further.
                    state_nxt = IDLE;
                    cnt_nxt   = 15'd0;
                    idx_nxt   = 4'd0;
                end else if (bit_index == n_lat + 4'd1) begin
                    // The stop-bit strobe was issued last cycle.
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    cnt_nxt   = 15'd0;
                end else if (cnt == 15'd0) begin
                    strobe_nxt = 1'b1;
                    idx_nxt    = bit_index + 4'd1;
                    cnt_nxt    = {1'b0, p_lat} - 15'd1;
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            DONE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                // A new packet needs enable_timer to drop first.
                if (!enable_timer) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 15'd0;
            p_lat        <= 14'd0;
            n_lat        <= 4'd0;
            bit_index    <= 4'd0;
            shift_strobe <= 1'b0;
            packet_done  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            p_lat        <= p_nxt;
            n_lat        <= n_nxt;
            bit_index    <= idx_nxt;
            shift_strobe <= strobe_nxt;
            packet_done  <= done_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rx_timer_ctrl.sv
// ============================================================================
// tb_rx_timer_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for rx_timer_ctrl. Expected outputs are derived for each
// cycle after the packet start edge E0, using arithmetic on the clamped period
// and bit count. The bench also honours RX_TIMER_MIDSAMPLE_EN when it is
// defined for the build.
// ============================================================================
module tb_rx_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_timer = 1'b0;
    logic [13:0] bit_period = 14'd0;
    logic [3:0]  data_bits = 4'd0;
    logic        shift_strobe;
    logic        packet_done;
    logic [3:0]  bit_index;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    rx_timer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .bit_period   (bit_period),
        .data_bits    (data_bits),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .bit_index    (bit_index),
        .busy         (busy)
    );

    // Drives one packet that starts at the next edge (E0 = edge 0).
    // abort_k  : edge at which enable_timer is first sampled low inside the packet (-1 = none)
    // hold_ext : extra edges enable_timer stays high after packet_done
    // rst_k    : if >= 0, stop after edge rst_k and assert rst mid-cycle
    task automatic run_packet(input string tag, input int p_raw, input int n_raw,
                              input int abort_k, input int hold_ext, input int rst_k);
        int p, n, f, done_k, a, idle_k, last_k, j, exp_i;
        bit aborted, exp_s, exp_d, exp_b;
        p = (p_raw < 2) ? 2 : p_raw;
        n = (n_raw < 5 || n_raw > 8) ? 8 : n_raw;
`ifdef RX_TIMER_MIDSAMPLE_EN
        f = p + p / 2;
`else
        f = p;
`endif
        done_k  = f + n * p + 1;
        aborted = (abort_k >= 0) && (abort_k <= done_k);
        a       = aborted ? abort_k : done_k + 1 + hold_ext;
        idle_k  = aborted ? a : ((a > done_k + 1) ? a : done_k + 2);
        last_k  = (rst_k >= 0) ? rst_k : idle_k + 1;

        @(negedge clk);
        rst          = 1'b0;
        enable_timer = 1'b1;
        bit_period   = p_raw[13:0];
        data_bits    = n_raw[3:0];

        for (int k = 0; k <= last_k; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_s = (k < a) && (k >= f) && ((k - f) % p == 0) && ((k - f) / p <= n);
            exp_d = !aborted && (k == done_k);
            if ((aborted && k >= a) || k < f) begin
                exp_i = 0;
            end else begin
                j     = (k - f) / p + 1;
                exp_i = (j > n + 1) ? n + 1 : j;
            end
            exp_b = (k < idle_k);

            vectors++;
            if (shift_strobe !== exp_s) begin
                errors++;
                $display("FAIL %s strobe E0+%0d: got %b want %b (P=%0d N=%0d)", tag, k, shift_strobe, exp_s, p, n);
            end
            vectors++;
            if (packet_done !== exp_d) begin
                errors++;
                $display("FAIL %s done E0+%0d: got %b want %b", tag, k, packet_done, exp_d);
            end
            vectors++;
            if (bit_index !== exp_i[3:0]) begin
                errors++;
                $display("FAIL %s bit_index E0+%0d: got %0d want %0d", tag, k, bit_index, exp_i);
            end
            vectors++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL %s busy E0+%0d: got %b want %b", tag, k, busy, exp_b);
            end

            // Input changes while busy must be ignored.
            enable_timer = (k + 1 < a);
            bit_period   = 14'($urandom);
            data_bits    = 4'($urandom);
        end

        if (rst_k >= 0) begin
            #2 rst = 1'b1;
            #1;
            vectors++;
            if ({shift_strobe, packet_done, busy, bit_index} !== 7'd0) begin
                errors++;
                $display("FAIL %s async_rst: got s=%b d=%b b=%b i=%0d want all 0", tag, shift_strobe, packet_done, busy, bit_index);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        enable_timer = 1'b1;
        bit_period   = 14'd10;
        data_bits    = 4'd8;
        #1;
        vectors++;
        if ({shift_strobe, packet_done, busy, bit_index} !== 7'd0) begin
            errors++;
            $display("FAIL reset_async: got s=%b d=%b b=%b i=%0d want all 0", shift_strobe, packet_done, busy, bit_index);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({shift_strobe, packet_done, busy, bit_index} !== 7'd0) begin
                errors++;
                $display("FAIL reset_held cycle %0d: got s=%b d=%b b=%b i=%0d want all 0", c, shift_strobe, packet_done, busy, bit_index);
            end
        end
        // The first edge after release is used as E0.
        run_packet("first_after_reset", 10, 8, -1, 0, -1);
    endtask

    task automatic test_basic();
        run_packet("basic_p10_n8", 10, 8, -1, 0, -1);
        run_packet("basic_p7_n5", 7, 5, -1, 0, -1);
        run_packet("basic_p3_n6", 3, 6, -1, 1, -1);
    endtask

    task automatic test_clamp();
        run_packet("clamp_p1_n3", 1, 3, -1, 0, -1);
        run_packet("clamp_p0_n15", 0, 15, -1, 0, -1);
        run_packet("clamp_p2_n4", 2, 4, -1, 0, -1);
        run_packet("clamp_p5_n9", 5, 9, -1, 0, -1);
    endtask

    task automatic test_abort();
        // enable_timer dropped after edge E0+35, first sampled low at E0+36
        run_packet("abort_35", 10, 8, 36, 0, -1);
        // drop coinciding with a strobe edge, and with the packet_done edge
        run_packet("abort_on_strobe", 4, 5, 12, 0, -1);
        run_packet("abort_on_done", 4, 5, 25, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_packet("hold5", 10, 8, -1, 5, -1);
        run_packet("restart", 6, 7, -1, 0, -1);
    endtask

    task automatic test_reset_mid();
        run_packet("rst_mid", 10, 8, -1, 0, 47);
        enable_timer = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({shift_strobe, packet_done, busy, bit_index} !== 7'd0) begin
                errors++;
                $display("FAIL rst_mid_held cycle %0d: got s=%b d=%b b=%b i=%0d want all 0", c, shift_strobe, packet_done, busy, bit_index);
            end
        end
        run_packet("after_rst_mid", 10, 8, -1, 0, -1);
    endtask

    task automatic test_random();
        int p, n, ab, hx;
        for (int r = 0; r < 12; r++) begin
            p  = int'($urandom_range(0, 24));
            n  = int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 120)) : -1;
            hx = int'($urandom_range(0, 4));
            run_packet("random", p, n, ab, hx, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
